serial_seq_gen: RTL and testbench
=================================

SERIAL_SEQ_GEN -- requirements
Module: serial_seq_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the maximum pattern length in bits.
REQ-002 The block SHALL have parameter LEN_W, default 5, equal to clog2(WIDTH)+1, which sets the width of the length fields.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin emitting a pattern.
REQ-006 The block SHALL have port data, input, WIDTH bits: pattern word, sampled with start.
REQ-007 The block SHALL have port len, input, LEN_W bits: number of bits to emit, sampled with start.
REQ-008 The block SHALL have port loop, input, 1 bit: repeat the pattern continuously, sampled with start.
REQ-009 The block SHALL have port stop, input, 1 bit: abort request.
REQ-010 The block SHALL have port out, output, 1 bit: serial bit stream, registered.
REQ-011 The block SHALL have port valid, output, 1 bit: out carries a pattern bit this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: the block is not in IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-014 The block SHALL have port bit_idx, output, LEN_W bits: index of the bit currently on out.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT, FINISH.
REQ-016 In IDLE with start=1 and len!=0, the block SHALL capture data, len and loop at that edge and enter SHIFT.
- out SHALL equal data[len-1] and valid=1 in the cycle immediately after that edge (latency 1).
REQ-017 Any len>WIDTH SHALL be clamped to WIDTH.
REQ-018 start with len=0 SHALL be ignored; the block stays in IDLE.
REQ-019 The pattern SHALL be emitted MSB-first, from captured bit len-1 down to bit 0.
- Each bit SHALL be held exactly one clock.
- bit_idx SHALL track the index of the bit on out.
REQ-020 In SHIFT, start SHALL be ignored, and data, len and loop changes SHALL have no effect.
REQ-021 After bit 0 with loop=0, the FSM SHALL enter FINISH for one cycle.
- In FINISH: done=1, valid=0, out=0.
- The FSM SHALL then return to IDLE.
REQ-022 After bit 0 with loop=1, out SHALL be bit len-1 again in the very next cycle, with no gap, no FINISH and no done.
REQ-023 When stop=1 in SHIFT, the next edge SHALL force IDLE with out=0, valid=0, and no done pulse.
- stop SHALL take priority over wrap-around and over the last-bit transition.
REQ-024 stop in IDLE or FINISH SHALL have no effect.
REQ-025 start sampled in FINISH SHALL be ignored; a new pattern needs start in IDLE.
REQ-026 In IDLE, outputs SHALL be out=0, valid=0, done=0, busy=0, bit_idx=0.
REQ-027 len=1 SHALL give one valid bit followed by FINISH; with loop=1 it SHALL repeat that bit every cycle.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force IDLE and set out=0, valid=0, busy=0, done=0, bit_idx=0, and clear the captured pattern registers.
REQ-029 Reset asserted mid-pattern SHALL abandon the pattern; no done pulse SHALL follow deassertion.
REQ-030 The first start after reset deassertion SHALL be honoured on the first clock edge.

Structure
REQ-031 Package seq_gen_pkg SHALL hold the WIDTH and LEN_W defaults and the state encoding constants (IDLE, SHIFT, FINISH).
REQ-032 One sub-module, piso_shift, SHALL hold the parallel-load, MSB-first shift register with reload-on-wrap.
- The FSM and the bit counter SHALL stay in serial_seq_gen.

Verification
REQ-033 start with data=16'h000B, len=4, loop=0 -> out=1,0,1,1 on cycles 1-4, valid=1 on those cycles, done=1 on cycle 5, then IDLE.
REQ-034 start with data=16'h00D9, len=10, loop=0 -> out=0,0,1,1,0,1,1,0,0,1 on cycles 1-10, done=1 on cycle 11; this stream drives sequence detector fsm_beh end-to-end.
REQ-035 start with data=16'h0005, len=3, loop=1 -> out=1,0,1,1,0,1,... with no gap; stop asserted on cycle 5 -> out=0, valid=0 on cycle 6, done never asserted.
REQ-036 start with len=0 -> busy stays 0; start with len=20 -> exactly 16 bits emitted.
REQ-037 rst pulsed asynchronously between clock edges during bit 2 of a 4-bit pattern -> all outputs 0 before the next edge, and no done pulse.
REQ-038 start re-asserted during SHIFT and during FINISH -> ignored; the original pattern completes unchanged.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared defaults and FSM state encoding for the serial sequence generator.
//   DEFAULT_WIDTH : default maximum pattern length in bits
//   DEFAULT_LEN_W : default width of length / index fields (clog2(WIDTH)+1)
//   IDLE/SHIFT/FINISH : FSM state codes
package seq_gen_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_LEN_W = 5;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, MSB-first, with reload-on-wrap.
// The pattern is left-aligned on load so bit len-1 sits in the MSB; a copy of
// the aligned pattern is kept so a looping pattern can be reloaded with no gap.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture data aligned to len (len must be 1..WIDTH)
//   shift    : advance to the next bit
//   reload   : restart from the stored aligned pattern
//   clear    : zero both the shift register and the stored pattern
//   data,len : pattern word and effective length
//   msb      : bit currently presented (the serial output)
module piso_shift
    import seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             reload,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    output logic             msb
);

    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] aligned;
    logic [LEN_W-1:0] shamt;

    // Bits above len-1 fall off the top; zeros fill below the pattern, so the
    // register drains to zero after the last bit.
    always_comb begin
        shamt   = LEN_W'(WIDTH) - len;
        aligned = data << shamt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            sh_q  <= '0;
        end else if (clear) begin
            pat_q <= '0;
            sh_q  <= '0;
        end else if (load) begin
            pat_q <= aligned;
            sh_q  <= aligned;
        end else if (reload) begin
            sh_q <= pat_q;
        end else if (shift) begin
            sh_q <= sh_q << 1;
        end
    end

    assign msb = sh_q[WIDTH-1];

endmodule

// File: rtl/serial_seq_gen.sv
// Serial sequence generator: captures a pattern word on start and emits its
// low len bits MSB-first, one per clock, optionally looping until stop.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a pattern (honoured only in IDLE with len != 0)
//   data      : pattern word, sampled with start
//   len       : bits to emit, sampled with start, clamped to WIDTH
//   loop      : repeat continuously, sampled with start
//   stop      : abort an active pattern (no done pulse)
//   out       : serial bit stream
//   valid     : out carries a pattern bit
//   busy      : not in IDLE
//   done      : one-cycle pulse on normal completion
//   bit_idx   : index of the bit currently on out
module serial_seq_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic             loop,
    input  logic             stop,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bit_idx
);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             loop_q, loop_d;
    logic [LEN_W-1:0] len_eff;
    logic             sh_load, sh_shift, sh_reload, sh_clear;

    assign len_eff = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        loop_d    = loop_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_reload = 1'b0;
        sh_clear  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d = SHIFT;
                    idx_d   = len_eff - LEN_W'(1);
                    len_d   = len_eff;
                    loop_d  = loop;
                    sh_load = 1'b1;
                end
            end
            SHIFT: begin
                // stop outranks both wrap-around and the last-bit exit
                if (stop) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    len_d    = '0;
                    loop_d   = 1'b0;
                    sh_clear = 1'b1;
                end else if (idx_q == '0) begin
                    if (loop_q) begin
                        idx_d     = len_q - LEN_W'(1);
                        sh_reload = 1'b1;
                    end else begin
                        state_d  = FINISH;
                        sh_clear = 1'b1;
                    end
                end else begin
                    idx_d    = idx_q - LEN_W'(1);
                    sh_shift = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                len_d   = '0;
                loop_d  = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                idx_d    = '0;
                len_d    = '0;
                loop_d   = 1'b0;
                sh_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
        end
    end

    piso_shift #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_piso (
        .clk    (clk),
        .rst    (rst),
        .load   (sh_load),
        .shift  (sh_shift),
        .reload (sh_reload),
        .clear  (sh_clear),
        .data   (data),
        .len    (len_eff),
        .msb    (out)
    );

    assign valid   = (state_q == SHIFT);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FINISH);
    assign bit_idx = idx_q;

endmodule

// File: tb/tb_serial_seq_gen.sv
module tb_serial_seq_gen;

    localparam int WIDTH = 16;
    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] len;
    logic             loop;
    logic             stop;
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] bit_idx;

    serial_seq_gen #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data    (data),
        .len     (len),
        .loop    (loop),
        .stop    (stop),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .bit_idx (bit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        bit b;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a pattern is the low eff bits of d, read from eff-1 down to 0;
    // a non-looping pattern ends with one done cycle, a looping one shows
    // exactly k bits before stop takes effect.
    task automatic model_push(input logic [WIDTH-1:0] d, input int l, input bit lp,
                              input int k);
        int   eff;
        int   p;
        exp_t e;
        eff = (l > WIDTH) ? WIDTH : l;
        if (eff == 0) return;
        if (!lp) begin
            for (int j = 0; j < eff; j++) begin
                p = eff - 1 - j;
                e.is_done = 1'b0; e.b = d[p]; e.idx = p;
                exp_q.push_back(e);
            end
            e.is_done = 1'b1; e.b = 1'b0; e.idx = 0;
            exp_q.push_back(e);
        end else begin
            for (int j = 0; j < k; j++) begin
                p = eff - 1 - (j % eff);
                e.is_done = 1'b0; e.b = d[p]; e.idx = p;
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: every valid/done cycle consumes one expected entry; every other
    // cycle must show the idle output values.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            if (valid || done) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got valid=%b done=%b out=%b required none",
                             valid, done, out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done)
                        check("done_cycle", {23'd0, valid, done, out, busy, bit_idx},
                              {23'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0});
                    else
                        check("pattern_bit", {23'd0, valid, done, out, busy, bit_idx},
                              {23'd0, 1'b1, 1'b0, e.b, 1'b1, 5'(e.idx)});
                end
            end else begin
                check("idle_outputs", {27'd0, out, busy, done, 2'b00} | {27'd0, bit_idx}, 32'd0);
            end
        end
    end

    task automatic run_pattern(input logic [WIDTH-1:0] d, input int l, input bit lp,
                               input int k, input bit noise);
        int eff;
        eff   = (l > WIDTH) ? WIDTH : l;
        start = 1'b1;
        data  = d;
        len   = LEN_W'(l);
        loop  = lp;
        stop  = 1'b0;
        model_push(d, l, lp, k);
        @(posedge clk); #1;
        start = 1'b0;
        if (eff != 0) begin
            if (!lp) begin
                for (int i = 1; i <= eff + 1; i++) begin
                    if (noise) begin
                        start = 1'($urandom);
                        data  = WIDTH'($urandom);
                        len   = LEN_W'($urandom);
                        loop  = 1'($urandom);
                        stop  = (i == eff + 1) ? 1'($urandom) : 1'b0;
                    end
                    @(posedge clk); #1;
                end
            end else begin
                for (int i = 1; i < k; i++) begin
                    if (noise) begin
                        start = 1'($urandom);
                        data  = WIDTH'($urandom);
                        len   = LEN_W'($urandom);
                        loop  = 1'($urandom);
                    end
                    @(posedge clk); #1;
                end
                start = 1'b0;
                stop  = 1'b1;
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            stop = 1'($urandom);
            @(posedge clk); #1;
        end
        stop = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [WIDTH-1:0] d;
        rst   = 1'b1;
        start = 1'b0;
        data  = '0;
        len   = '0;
        loop  = 1'b0;
        stop  = 1'b0;
        #1;
        check("reset_state", {27'd0, out, valid, busy, done, 1'b0} | {27'd0, bit_idx}, 32'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        run_pattern(16'h000B, 4, 1'b0, 0, 1'b0);
        idle_gap(2);
        run_pattern(16'h00D9, 10, 1'b0, 0, 1'b0);
        idle_gap(1);
        run_pattern(16'h0005, 3, 1'b1, 5, 1'b0);
        idle_gap(2);
        run_pattern(16'hFFFF, 0, 1'b0, 0, 1'b0);
        idle_gap(2);
        run_pattern(16'hA5C3, 20, 1'b0, 0, 1'b0);
        idle_gap(1);
        run_pattern(16'h000B, 4, 1'b0, 0, 1'b1);
        run_pattern(16'h0001, 1, 1'b1, 4, 1'b0);
        run_pattern(16'h0001, 1, 1'b0, 0, 1'b0);
        idle_gap(1);

        // Asynchronous reset while bit index 2 of a 4-bit pattern is on out
        d     = 16'h000D;
        start = 1'b1;
        data  = d;
        len   = 5'd4;
        loop  = 1'b0;
        e.is_done = 1'b0; e.b = d[3]; e.idx = 3; exp_q.push_back(e);
        e.is_done = 1'b0; e.b = d[2]; e.idx = 2; exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #6;
        rst = 1'b1;
        #1;
        check("async_reset", {27'd0, out, valid, busy, done, 1'b0} | {27'd0, bit_idx}, 32'd0);
        rst = 1'b0;
        #1;
        check("reset_drain", 32'(exp_q.size()), 32'd0);
        // First start after reset must be honoured on the very next edge
        run_pattern(16'h0036, 6, 1'b0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            run_pattern(WIDTH'($urandom), int'($urandom_range(0, 20)), 1'($urandom),
                        int'($urandom_range(1, 2 * WIDTH + 2)), 1'b1);
            idle_gap(int'($urandom_range(0, 3)));
        end

        idle_gap(3);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
